// File: rtl/mul_seq_pkg.sv
// Shared constants for the sequential shift-add multiplier: state encoding, default
// operand width and iteration count.
package mul_seq_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_ITERS = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_seq_cla.sv
// Carry-lookahead adder: 4-bit lookahead groups with group generate/propagate, combinational.
// WIDTH must be a multiple of 4.
module mul_seq_cla #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iCarry,
    output logic [WIDTH-1:0] oSum,
    output logic             oCarry
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] gen_b;
    logic [WIDTH-1:0] prop_b;

    assign gen_b    = iA & iB;
    assign prop_b   = iA ^ iB;
    assign carry[0] = iCarry;

    for (genvar k = 0; k < WIDTH / 4; k++) begin : g_grp
        logic [3:0] g;
        logic [3:0] p;
        logic       ci;
        logic       grp_g;
        logic       grp_p;

        assign g  = gen_b[4*k +: 4];
        assign p  = prop_b[4*k +: 4];
        assign ci = carry[4*k];

        assign carry[4*k+1] = g[0] | (p[0] & ci);
        assign carry[4*k+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        assign carry[4*k+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                            | (p[2] & p[1] & p[0] & ci);

        // Group terms let the next group's carry-in skip the in-group chain.
        assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0]);
        assign grp_p = &p;
        assign carry[4*k+4] = grp_g | (grp_p & ci);
    end

    assign oSum   = prop_b ^ carry[WIDTH-1:0];
    assign oCarry = carry[WIDTH];

endmodule

// File: rtl/mul_seq.sv
// Unsigned WIDTHxWIDTH shift-add multiplier, 32 iterations, oDone in the cycle after the 32nd; starts ignored while busy.
// MUL_SEQ_ZERO_BYPASS_EN: zero operand goes straight to DONE (oDone in the cycle after the accept).
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iX,
    input  logic [WIDTH-1:0] iY,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oHi,
    output logic [WIDTH-1:0] oLo,
    output logic             oZero
);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     add_s;
    logic                 add_c;

    // Adding zero when P[0] is clear yields {0, P_hi}, so one adder covers both cases.
    assign add_b = p_q[0] ? m_q : '0;

    mul_seq_cla #(
        .WIDTH (WIDTH)
    ) u_cla (
        .iA     (p_q[2*WIDTH-1:WIDTH]),
        .iB     (add_b),
        .iCarry (1'b0),
        .oSum   (add_s),
        .oCarry (add_c)
    );

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    m_d     = iX;
                    cnt_d   = '0;
                    p_d     = {{WIDTH{1'b0}}, iY};
                    state_d = RUN;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
                    if ((iX == '0) || (iY == '0)) begin
                        p_d     = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                p_d   = {add_c, add_s, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            p_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oBusy = (state_q != IDLE);
    assign oDone = (state_q == DONE);
    assign oHi   = p_q[2*WIDTH-1:WIDTH];
    assign oLo   = p_q[WIDTH-1:0];
    assign oZero = (p_q == '0);

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand width; SHALL equal the CLA adder width.
REQ-002 Port: iClk  input  1  rising-edge clock; SHALL be the only clock.
REQ-003 Port: iRst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 Port: iStart  input  1  request; a start is accepted only in IDLE.
REQ-005 Port: iX  input  WIDTH  multiplicand, unsigned; sampled on the accepting edge.
REQ-006 Port: iY  input  WIDTH  multiplier, unsigned; sampled on the accepting edge.
REQ-007 Port: oBusy  output  1  high in RUN and DONE.
REQ-008 Port: oDone  output  1  one-cycle completion pulse.
REQ-009 Port: oHi  output  WIDTH  upper product word.
REQ-010 Port: oLo  output  WIDTH  lower product word.
REQ-011 Port: oZero  output  1  high when {oHi,oLo} == 0.

Function
REQ-012 States SHALL be IDLE, RUN and DONE.
REQ-013 IDLE with iStart=1 at edge E0: SHALL latch iX into M, clear the 6-bit counter, and load P={0,iY}; next state RUN.
REQ-014 RUN, each edge: if P[0]=1, the block SHALL compute {c,s}=P[63:32]+M through the single CLA instance (iCarry tied 0); otherwise {c,s}={0,P[63:32]}.
REQ-015 RUN, each edge: P SHALL become {c,s,P[31:1]} (65-bit right shift), and the counter SHALL increment by 1.
REQ-016 The edge on which the counter reaches 31 SHALL perform the 32nd iteration and move the state to DONE, so that the 32 iterations occur on edges E1..E32.
REQ-017 DONE SHALL hold for exactly one cycle with oDone=1; the next state SHALL be IDLE unconditionally.
REQ-018 oHi/oLo SHALL equal P[63:32]/P[31:0] and SHALL hold their value through IDLE until the next accepted start.
REQ-019 Latency without bypass: oDone SHALL be high during the cycle after E32.
REQ-020 iStart in RUN or DONE SHALL be ignored (no queueing).
REQ-021 An iStart level held high SHALL start a new operation on the first IDLE edge after DONE.
REQ-022 Operand changes on iX/iY while busy SHALL NOT affect the result.
REQ-023 The product SHALL be exact modulo 2^64, with no overflow case; the CLA carry SHALL be the only carry source.

Reset
REQ-024 When iRst=1 on an edge, the state SHALL become IDLE and P, M and the counter SHALL clear.
REQ-025 Reset values: oBusy=0, oDone=0, oHi=0, oLo=0, oZero=1.
REQ-026 iRst SHALL have priority over iStart and over any in-flight iteration; a reset mid-RUN discards the operation and produces no oDone.

Configuration
REQ-027 The macro MUL_SEQ_ZERO_BYPASS_EN SHALL control a zero-operand bypass.
REQ-028 With the macro defined: an accepted start with iX==0 or iY==0 SHALL load P=0 and go directly IDLE->DONE, so oDone is high in the cycle after E0.
REQ-029 Without the macro: zero operands SHALL take the full 32-iteration path with the REQ-019 latency.
REQ-030 Results SHALL be identical in both builds.

Structure
REQ-031 A shared package/header mul_seq_pkg SHALL hold the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the WIDTH default and the iteration count (32).
REQ-032 The adder SHALL be the existing CLA instantiated as the sole sub-module; no other arithmetic operator SHALL appear on the datapath.

Verification
REQ-033 Scenario: X=5, Y=10 -> oDone one cycle after E32; {oHi,oLo}=0x0000_0000_0000_0032; oZero=0.
REQ-034 Scenario: X=Y=0xFFFF_FFFF -> oHi=0xFFFF_FFFE, oLo=0x0000_0001.
REQ-035 Scenario: start X=400, Y=33, then pulse iStart with X=1, Y=7 at E10 -> result 13200 (0x3390); exactly one oDone pulse.
REQ-036 Scenario: start X=7, Y=9, assert iRst at E15 -> IDLE with all outputs at reset values; no oDone; a fresh start X=3, Y=4 then yields 12.
REQ-037 Scenario: X=0, Y=123 -> oZero=1; oDone in the cycle after E0 with MUL_SEQ_ZERO_BYPASS_EN defined, after E32 without it.
REQ-038 Scenario: 10,000 random operand pairs, with iStart held high -> every result matches the 64-bit reference product, and back-to-back starts are spaced 34 cycles apart.
